fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle core's decode/execute datapath.
- Sequences fetch addresses, issues single-outstanding requests to a variable-latency instruction memory, and buffers returned words in a small FIFO.
- Presents one {pc, instr} pair per valid/ready handshake to the consumer.
- A redirect input (branch/jump/jr target from the core) flushes all buffered and in-flight work and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req  out  1  one-cycle request pulse; memory always accepts.
- imem_addr  out  32  word address of the request; valid while imem_req=1.
- imem_rvalid  in  1  response strobe, >= 1 cycle after the accepted imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 00.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_pc  out  32  PC of head instruction; 0 when out_valid=0.
- out_instr  out  32  head instruction word; 0 when out_valid=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, fetch_pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, out_pc=0, out_instr=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, its response will be kept.
  - DROP: one request outstanding, its response will be discarded.
- Issue:
  - Issue only in IDLE, when redirect_valid=0 and count < DEPTH.
  - A pop in the same cycle is not credited.
  - On issue: imem_req=1, imem_addr=fetch_pc, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), state->WAIT.
- Response in WAIT:
  - On imem_rvalid, push {req_pc, imem_rdata} at the tail and go to IDLE.
  - Push never overflows, because issue reserved the slot.
- Response in DROP:
  - On imem_rvalid, discard the data and go to IDLE.
- imem_rvalid while in IDLE: protocol violation; ignore it.
- Pop: when out_valid && out_ready, advance the head and decrement count. Push and pop in the same cycle leave count unchanged.
- Redirect has the highest priority:
  - count<=0 and head/tail pointers reset; any push or pop that cycle is suppressed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No issue that cycle.
  - State: WAIT -> DROP, unless imem_rvalid arrives in the same cycle, in which case the response is discarded and the state goes to IDLE. DROP stays DROP, unless imem_rvalid arrives the same cycle, in which case it goes to IDLE. IDLE stays IDLE.
  - out_valid deasserts the cycle after the redirect.
- Back-to-back redirects: the last one wins; at most one stale response is ever dropped.
- Latency (no bypass), with a 1-cycle memory:
  - req at cycle t, rvalid at t+1, out_valid at t+2.
  - Sustained throughput: 1 instruction per 2 cycles.
- Outputs are registered FIFO head contents; out_pc and out_instr are forced to 0 when out_valid=0.
- Reset mid-request: the outstanding request is forgotten. The memory must not return a response after reset is released.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined:
  - When count==0 (after any redirect) and a kept response arrives, out_valid=1 combinationally in the same cycle, with out_pc=req_pc and out_instr=imem_rdata.
  - If out_ready=1 that cycle, the word is consumed and not pushed; otherwise it is pushed normally.
  - Latency drops to 1 cycle after rvalid.
  - Redirect in the same cycle kills the bypass (out_valid=0).
- Undefined: no combinational path from imem_* to out_*; latency as in Behaviour.

Test Plan:
- Reset release, 1-cycle memory returning word = addr, out_ready=1 -> imem_addr sequence 3000, 3004, 3008; outputs (3000, 00003000), (3004, 00003004), ... with out_valid every 2nd cycle.
- out_ready=0 for 20 cycles -> exactly 4 requests (DEPTH=4), then imem_req stays 0. Raising out_ready pops in order 3000..300C; fetching resumes at 3010.
- Memory latency 3; redirect_valid=1 with redirect_pc=32'h0000_4003 one cycle after req(3004) -> FIFO flushed; the 3004 response dropped; next imem_addr=4000; first out_pc=4000.
- Redirect coincident with imem_rvalid in WAIT -> response not enqueued; state IDLE; issue to the redirect target on the next cycle.
- Redirect to FFFF_FFFC -> requests FFFF_FFFC, then 0000_0000; out_pc values match.
- With FETCHQ_BYPASS_EN: empty FIFO, rvalid with rdata=0x2408_0005 -> out_valid=1 in the same cycle with that instr. Without the macro, it appears one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: single-outstanding imem requests feeding a DEPTH-entry {pc, instr} FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        pc_mem_q [DEPTH];
  logic [31:0]        pc_mem_d [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];

  logic issue;
  logic resp_kept;
  logic bypass;
  logic fire;
  logic push;
  logic pop_fifo;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)         state_d = IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue     = (state_q == IDLE) && !redirect_valid && (count_q < DEPTH_C);
    // Gated by reset so no request pulse escapes while reset is held.
    imem_req  = issue && reset;
    imem_addr = fetch_pc_q;
    resp_kept = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    out_pc    = '0;
    out_instr = '0;
`ifdef FETCHQ_BYPASS_EN
    bypass    = resp_kept && (count_q == '0);
    out_valid = (count_q != '0) || bypass;
    if (count_q != '0) begin
      out_pc    = pc_mem_q[head_q];
      out_instr = instr_mem_q[head_q];
    end else if (bypass) begin
      out_pc    = req_pc_q;
      out_instr = imem_rdata;
    end
`else
    bypass    = 1'b0;
    out_valid = (count_q != '0);
    if (count_q != '0) begin
      out_pc    = pc_mem_q[head_q];
      out_instr = instr_mem_q[head_q];
    end
`endif
  end

  // FIFO and fetch-PC datapath
  always_comb begin
    fire     = out_valid && out_ready && !redirect_valid;
    pop_fifo = fire && (count_q != '0);
    // A bypassed word that is consumed on arrival never occupies a slot.
    push     = resp_kept && !(bypass && out_ready);

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = req_pc_q;
        instr_mem_d[tail_q] = imem_rdata;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (pop_fifo) head_d = head_q + PTR_W'(1);
      unique case ({push, pop_fifo})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: transaction-level queue model plus a variable-latency memory.
// Follows FETCHQ_BYPASS_EN to pick the expected bypass behaviour.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffered entries plus one in-flight request record.
  ent_t        q[$];
  logic [31:0] m_fpc;
  bit          m_pend, m_stale;
  logic [31:0] m_ppc;

  // Memory model and observation records.
  bit          mem_busy = 0;
  int          mem_left = 0;
  logic [31:0] mem_addr = '0;
  int          lat = 1;
  logic [31:0] mask = '0;
  bit          fix_en = 0;
  logic [31:0] fix_data = '0;
  logic [31:0] reqs[$];
  logic [31:0] pops[$];
  bit          obs_req, obs_ov;
  logic [31:0] obs_addr, obs_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
    mem_busy = 0;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, RESET_PC);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    q.delete(); m_fpc = RESET_PC; m_pend = 0; m_stale = 0; m_ppc = '0;
    reqs.delete(); pops.delete();
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit rv, e_req, byp, e_ov;
    int qs;
    logic [31:0] e_pc, e_in, data;
    @(negedge clk);
    rv = 0;
    if (mem_busy) begin
      if (mem_left <= 1) begin rv = 1; mem_busy = 0; end
      else mem_left--;
    end
    data = fix_en ? fix_data : (mem_addr ^ mask);
    imem_rvalid = rv;
    imem_rdata = rv ? data : $urandom();
    redirect_valid = redir; redirect_pc = rpc; out_ready = rdy;
    #1;
    qs    = q.size();
    e_req = !m_pend && !redir && (qs < DEPTH);
    byp   = BYP && m_pend && !m_stale && rv && !redir && (qs == 0);
    e_ov  = (qs > 0) || byp;
    e_pc  = (qs > 0) ? q[0].pc    : (byp ? m_ppc : 32'd0);
    e_in  = (qs > 0) ? q[0].instr : (byp ? imem_rdata : 32'd0);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", out_instr, e_in);
    obs_req = imem_req; obs_addr = imem_addr; obs_ov = out_valid; obs_instr = out_instr;
    if (out_valid && rdy && !redir) pops.push_back(out_pc);
    if (imem_req) begin
      mem_busy = 1; mem_left = lat; mem_addr = imem_addr;
      reqs.push_back(imem_addr);
    end
    if (redir) begin
      q.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (m_pend && rv) m_pend = 0;
      if (m_pend) m_stale = 1;
    end else begin
      if (e_ov && rdy && qs > 0) void'(q.pop_front());
      if (m_pend && rv) begin
        if (!m_stale && !(byp && rdy)) q.push_back('{pc: m_ppc, instr: imem_rdata});
        m_pend = 0;
      end
      if (e_req) begin
        m_pend = 1; m_stale = 0; m_ppc = m_fpc; m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    // Streaming with a 1-cycle memory returning word = addr.
    do_reset(); lat = 1; mask = '0; fix_en = 0;
    repeat (12) step(0, '0, 1);
    chk("seq_req0", (reqs.size() > 0) ? reqs[0] : 'x, 32'h3000);
    chk("seq_req1", (reqs.size() > 1) ? reqs[1] : 'x, 32'h3004);
    chk("seq_req2", (reqs.size() > 2) ? reqs[2] : 'x, 32'h3008);
    chk("seq_req_count", reqs.size(), 32'd6);

    // Stalled consumer fills the FIFO, then drains in order.
    do_reset();
    repeat (20) step(0, '0, 0);
    chk("full_req_count", reqs.size(), 32'd4);
    chk("full_req_idle", 32'(obs_req), 32'd0);
    reqs.delete(); pops.delete();
    repeat (20) step(0, '0, 1);
    chk("resume_addr", (reqs.size() > 0) ? reqs[0] : 'x, 32'h3010);
    for (int i = 0; i < 4; i++)
      chk("drain_order", (pops.size() > i) ? pops[i] : 'x, 32'h3000 + 32'(4 * i));

    // Redirect while the 3004 request is in flight with latency 3.
    do_reset(); lat = 3; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(0, '0, 1);
      if (obs_req && obs_addr == 32'h3004) found = 1;
    end
    chk("saw_req_3004", 32'(found), 32'd1);
    step(1, 32'h0000_4003, 1);
    reqs.delete(); pops.delete();
    repeat (30) step(0, '0, 1);
    chk("redir_first_req", (reqs.size() > 0) ? reqs[0] : 'x, 32'h4000);
    chk("redir_first_pop", (pops.size() > 0) ? pops[0] : 'x, 32'h4000);

    // Redirect coincident with the response.
    do_reset(); lat = 2;
    step(0, '0, 0);
    step(0, '0, 0);
    step(1, 32'h0000_5000, 0);
    step(0, '0, 0);
    chk("coinc_issue", 32'(obs_req), 32'd1);
    chk("coinc_addr", obs_addr, 32'h5000);
    chk("coinc_empty", 32'(obs_ov), 32'd0);

    // Fetch PC wrap at the top of the address space.
    lat = 1;
    step(1, 32'hFFFF_FFFC, 1);
    reqs.delete(); pops.delete();
    repeat (16) step(0, '0, 1);
    chk("wrap_req0", (reqs.size() > 0) ? reqs[0] : 'x, 32'hFFFF_FFFC);
    chk("wrap_req1", (reqs.size() > 1) ? reqs[1] : 'x, 32'h0000_0000);
    chk("wrap_pop0", (pops.size() > 0) ? pops[0] : 'x, 32'hFFFF_FFFC);
    chk("wrap_pop1", (pops.size() > 1) ? pops[1] : 'x, 32'h0000_0000);

    // Response into an empty FIFO: same-cycle only with bypass.
    do_reset(); lat = 1; fix_en = 1; fix_data = 32'h2408_0005;
    step(0, '0, 0);
    step(0, '0, 0);
    chk("byp_valid", 32'(obs_ov), 32'(BYP));
    chk("byp_instr", obs_instr, BYP ? 32'h2408_0005 : 32'd0);
    step(0, '0, 0);
    chk("late_valid", 32'(obs_ov), 32'd1);
    chk("late_instr", obs_instr, 32'h2408_0005);
    fix_en = 0;

    // Randomized traffic: latency, back-pressure, redirects, data pattern.
    do_reset(); mask = $urandom();
    for (int i = 0; i < 800; i++) begin
      if (i % 37 == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 3) != 0);
    end

    // Reset while a request is outstanding.
    lat = 3;
    step(0, '0, 1);
    step(0, '0, 1);
    do_reset();
    repeat (10) step(0, '0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
